// File: rtl/bios_loader.sv
// bios_loader: packs the data_io byte stream into 16-bit little-endian words,
// buffers them in a two-bank ping-pong memory and hands each full bank to the
// core's BIOS load port. bios_loaded is raised once the whole image is consumed.
//
// Ports:
//   clk_sys         system clock, all logic on the rising edge
//   reset           synchronous active-high reset
//   ioctl_download  high while a download is in progress
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address of ioctl_dout
//   ioctl_dout      download byte
//   bios_req        core pulls one word per cycle while high
//   bios_addr       word index of the word on bios_din
//   bios_din        delivered word
//   bios_wr         at least one bank is ready
//   bios_loaded     image fully delivered (sticky)
//   overflow        a write targeted a bank still waiting to be read (sticky)
module bios_loader #(
    parameter int unsigned BLOCK_WORDS = 32,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              bios_req,
    output logic [ADDR_W-1:0] bios_addr,
    output logic [15:0]       bios_din,
    output logic              bios_wr,
    output logic              bios_loaded,
    output logic              overflow
);
    localparam int unsigned DEPTH = 2 * BLOCK_WORDS;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned OW    = IW - 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state, state_n;
    logic              dl_q;
    logic [7:0]        lo_byte, lo_byte_n;
    logic              pending, pending_n;
    logic [IW-1:0]     wr_ptr, wr_ptr_n;
    logic [IW-1:0]     rd_ptr, rd_ptr_n;
    logic [ADDR_W-1:0] rd_count, rd_count_n;
    logic [1:0]        ready, ready_n;
    logic              overflow_n, loaded_n;

    logic              rise_c, fall_c, xfer_c;
    logic              wr_req_c, we_c, wbank_c;
    logic [IW-1:0]     widx_c;
    logic [15:0]       wdata_c;
    logic              unused_c;

    logic [15:0]       mem [DEPTH];

    assign rise_c   = ioctl_download & ~dl_q;
    assign fall_c   = ~ioctl_download & dl_q;
    assign xfer_c   = bios_req & bios_wr;
    assign wbank_c  = widx_c[IW-1];
    assign unused_c = ^ioctl_addr[24:IW+1];

    // Next-state, writer and reader bookkeeping
    always_comb begin
        state_n    = state;
        lo_byte_n  = lo_byte;
        pending_n  = pending;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        rd_count_n = rd_count;
        ready_n    = ready;
        overflow_n = overflow;
        loaded_n   = bios_loaded;
        wr_req_c   = 1'b0;
        we_c       = 1'b0;
        widx_c     = wr_ptr;
        wdata_c    = 16'hFFFF;

        case (state)
            S_RECV: begin
                if (fall_c) begin
                    // flush an unpaired trailing byte with a zero high half
                    if (pending) begin
                        wr_req_c  = 1'b1;
                        widx_c    = wr_ptr;
                        wdata_c   = {8'h00, lo_byte};
                        wr_ptr_n  = wr_ptr + 1'b1;
                        pending_n = 1'b0;
                    end
                    state_n = (wr_ptr_n[OW-1:0] != '0) ? S_PAD : S_DRAIN;
                end else if (ioctl_wr) begin
                    if (!ioctl_addr[0]) begin
                        lo_byte_n = ioctl_dout;
                        pending_n = 1'b1;
                        wr_ptr_n  = ioctl_addr[IW:1];
                    end else begin
                        wr_req_c  = 1'b1;
                        widx_c    = ioctl_addr[IW:1];
                        wdata_c   = {ioctl_dout, lo_byte};
                        wr_ptr_n  = ioctl_addr[IW:1] + 1'b1;
                        pending_n = 1'b0;
                    end
                end
            end
            S_PAD: begin
                wr_req_c = 1'b1;
                widx_c   = wr_ptr;
                wdata_c  = 16'hFFFF;
                wr_ptr_n = wr_ptr + 1'b1;
                if (&wr_ptr[OW-1:0]) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                // no bank ready means bios_wr is low, so nothing is in flight
                if (ready == '0) begin
                    state_n  = S_DONE;
                    loaded_n = 1'b1;
                end
            end
            default: ;
        endcase

        // writer: drop words aimed at a bank the core has not drained yet
        if (wr_req_c) begin
            if (ready[wbank_c]) begin
                overflow_n = 1'b1;
            end else begin
                we_c = 1'b1;
                if (&widx_c[OW-1:0]) ready_n[wbank_c] = 1'b1;
            end
        end

        // reader: clear comes after set so it wins on the same bank
        if (xfer_c) begin
            rd_ptr_n   = rd_ptr + 1'b1;
            rd_count_n = rd_count + 1'b1;
            if (&rd_ptr[OW-1:0]) ready_n[rd_ptr[IW-1]] = 1'b0;
        end

        // a new download restarts everything from scratch
        if (rise_c) begin
            state_n    = S_RECV;
            pending_n  = 1'b0;
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            rd_count_n = '0;
            ready_n    = '0;
            overflow_n = 1'b0;
            loaded_n   = 1'b0;
            we_c       = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            // follow the pin so a download held high through reset is not a new edge
            dl_q        <= ioctl_download;
            lo_byte     <= '0;
            pending     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_count    <= '0;
            ready       <= '0;
            bios_addr   <= '0;
            bios_din    <= '0;
            bios_wr     <= 1'b0;
            bios_loaded <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            dl_q        <= ioctl_download;
            lo_byte     <= lo_byte_n;
            pending     <= pending_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            rd_count    <= rd_count_n;
            ready       <= ready_n;
            bios_wr     <= |ready_n;
            bios_loaded <= loaded_n;
            overflow    <= overflow_n;
            if (rise_c) begin
                bios_addr <= '0;
            end else if (xfer_c) begin
                bios_addr <= rd_count;
                bios_din  <= mem[rd_ptr];
            end
        end
    end

    // Ping-pong buffer storage
    always_ff @(posedge clk_sys) begin
        if (we_c) mem[widx_c] <= wdata_c;
    end
endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: scoreboard bench for bios_loader. Each download pushes the
// expected (bios_addr, bios_din) stream computed from the byte image; a monitor
// pops and compares on every accepted bios_req/bios_wr handshake.
module tb_bios_loader;
    localparam int unsigned BW = 32;
    localparam int unsigned AW = 13;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          bios_req = 1'b0;
    logic [AW-1:0] bios_addr;
    logic [15:0]   bios_din;
    logic          bios_wr;
    logic          bios_loaded;
    logic          overflow;

    bios_loader #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .bios_req       (bios_req),
        .bios_addr      (bios_addr),
        .bios_din       (bios_din),
        .bios_wr        (bios_wr),
        .bios_loaded    (bios_loaded),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int       n_cmp = 0;
    int       n_fail = 0;
    int       exp_addr[$];
    int       exp_data[$];
    logic [7:0] img [256];
    int       words_seen = 0;
    logic     fire_q = 1'b0;
    logic     gap_watch = 1'b0;
    int       gap_cnt = 0;
    logic     wr_seen = 1'b0;
    logic     req_level = 1'b0;
    logic     req_mode = 1'b0;
    int       phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference: pair bytes little-endian, zero the missing high byte, pad the
    // last bank with FFFF; only max_words words survive if nobody reads meanwhile.
    task automatic expect_image(input int nbytes, input int max_words);
        int nw;
        int padded;
        logic [7:0] hi;
        nw = (nbytes + 1) / 2;
        padded = ((nw + int'(BW) - 1) / int'(BW)) * int'(BW);
        if (padded > max_words) padded = max_words;
        for (int w = 0; w < padded; w++) begin
            if (w < nw) begin
                hi = (2 * w + 1 < nbytes) ? img[8'(2 * w + 1)] : 8'h00;
                exp_data.push_back(int'({16'h0000, hi, img[8'(2 * w)]}));
            end else begin
                exp_data.push_back(32'h0000_FFFF);
            end
            exp_addr.push_back(w % (1 << AW));
        end
    endtask

    task automatic start_download();
        words_seen = 0;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send_bytes(input int first, input int last, input int gap, input int req_at);
        for (int i = first; i < last; i++) begin
            if (i == req_at) req_level = 1'b1;
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = img[8'(i)];
            tick();
            ioctl_wr = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic finish_download(input string name, input int bound);
        int n;
        ioctl_download = 1'b0;
        n = 0;
        while (!bios_loaded && n < bound) begin
            tick();
            n++;
        end
        check({name, "_loaded"}, 32'(bios_loaded), 32'd1);
        check({name, "_words"}, 32'(words_seen), 32'd64);
        check({name, "_queue_left"}, 32'(exp_data.size()), 32'd0);
    endtask

    // Request driver: level or one cycle in three
    always @(posedge clk_sys) begin
        #2;
        bios_req = req_mode ? (phase == 0) : req_level;
        phase = (phase == 2) ? 0 : phase + 1;
    end

    // Monitor: a handshake seen before an edge means a word after it
    always @(negedge clk_sys) begin
        int ea;
        int ed;
        if (reset) begin
            fire_q = 1'b0;
        end else begin
            if (fire_q) begin
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got addr %0h data %0h expected none", bios_addr, bios_din);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("bios_addr", 32'(bios_addr), 32'(ea));
                    check("bios_din", 32'(bios_din), 32'(ed));
                end
                words_seen++;
            end
            if (gap_watch && words_seen > 0 && words_seen < 64 && !bios_wr) gap_cnt++;
            if (bios_wr) wr_seen = 1'b1;
            fire_q = bios_req && bios_wr;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_bios_addr", 32'(bios_addr), 32'd0);
        check("rst_bios_din", 32'(bios_din), 32'd0);
        check("rst_bios_wr", 32'(bios_wr), 32'd0);
        check("rst_loaded", 32'(bios_loaded), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // 128 ascending bytes, core always requesting
        for (int i = 0; i < 128; i++) img[i] = 8'(i);
        expect_image(128, 1000);
        req_level = 1'b1;
        start_download();
        send_bytes(0, 128, 1, -1);
        n = 0;
        while (bios_wr && n < 200) begin
            tick();
            n++;
        end
        check("t1_wr_dropped", 32'(bios_wr), 32'd0);
        ioctl_download = 1'b0;
        n = 0;
        while (!bios_loaded && n < 10) begin
            tick();
            n++;
        end
        check("t1_loaded_within3", 32'(n <= 3 && bios_loaded), 32'd1);
        check("t1_words", 32'(words_seen), 32'd64);
        check("t1_queue_left", 32'(exp_data.size()), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);

        // 67 bytes: trailing odd byte plus FFFF padding
        for (int i = 0; i < 67; i++) img[i] = 8'(i);
        expect_image(67, 1000);
        start_download();
        send_bytes(0, 67, 1, -1);
        finish_download("t2", 400);
        check("t2_overflow", 32'(overflow), 32'd0);
        req_level = 1'b0;
        tick();

        // 192 random bytes, nobody reading: third bank overflows
        for (int i = 0; i < 192; i++) img[i] = 8'($urandom);
        expect_image(192, 2 * BW);
        start_download();
        send_bytes(0, 192, 1, -1);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_wr_high", 32'(bios_wr), 32'd1);
        ioctl_download = 1'b0;
        repeat (5) tick();
        check("t3_not_loaded_yet", 32'(bios_loaded), 32'd0);
        req_level = 1'b1;
        words_seen = 0;
        finish_download("t3", 200);
        req_level = 1'b0;
        tick();

        // bank 1 completes in the same cycle bank 0's last word is read
        for (int i = 0; i < 128; i++) img[i] = 8'($urandom);
        expect_image(128, 1000);
        gap_cnt = 0;
        gap_watch = 1'b1;
        start_download();
        send_bytes(0, 128, 0, 96);
        finish_download("t4", 200);
        gap_watch = 1'b0;
        check("t4_wr_continuous", 32'(gap_cnt), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);
        req_level = 1'b0;
        tick();

        // reset in the middle of a download that keeps going
        for (int i = 0; i < 80; i++) img[i] = 8'($urandom);
        req_level = 1'b1;
        start_download();
        wr_seen = 1'b0;
        send_bytes(0, 40, 1, -1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_bytes(40, 80, 1, -1);
        ioctl_download = 1'b0;
        repeat (40) tick();
        check("t5_no_wr", 32'(wr_seen), 32'd0);
        check("t5_not_loaded", 32'(bios_loaded), 32'd0);
        check("t5_no_words", 32'(words_seen), 32'd0);

        // fresh download after the reset works normally
        for (int i = 0; i < 100; i++) img[i] = 8'($urandom);
        expect_image(100, 1000);
        start_download();
        send_bytes(0, 100, 1, -1);
        finish_download("t5b", 300);
        req_level = 1'b0;
        tick();

        // request asserted one cycle in three
        for (int i = 0; i < 128; i++) img[i] = 8'($urandom);
        expect_image(128, 1000);
        req_mode = 1'b1;
        start_download();
        send_bytes(0, 128, 1, -1);
        finish_download("t6", 400);
        check("t6_overflow", 32'(overflow), 32'd0);
        req_mode = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
